urp_pcie_rr_arbiter: RTL and testbench
======================================

# urp_pcie_rr_arbiter

Parametrised N-way round-robin arbiter for the URP PCIe TLP path, merging `N_MASTER` valid/ready source streams into one registered destination stream. It supersedes the fixed two-master arbiter. It adds a packed per-master data bus, full backpressure-correct handshaking, optional packet locking on a `last` flag, and a granted-source ID output. It sits between the per-function TLP generators and the shared transmit datapath.

## Interface
- `N_MASTER`, default 4: number of source channels, ≥1; any value, power of two not required.
- `DATA_SIZE`, default 224: beat width in bits.
- `LOCK_PKT`, default 1: 1 keeps the grant on one master until it sends a beat with `last`=1; 0 re-arbitrates every beat.
- `ID_W` (localparam): `max(1, $clog2(N_MASTER))`.
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `src_valid_i`  in  N_MASTER  per-master beat valid.
- `src_ready_o`  out  N_MASTER  per-master accept; at most one bit high in any cycle.
- `src_data_i`  in  N_MASTER*DATA_SIZE  master i data at `[i*DATA_SIZE +: DATA_SIZE]`.
- `src_last_i`  in  N_MASTER  master i's beat ends its packet.
- `dst_valid_o`  out  1  registered output beat valid.
- `dst_ready_i`  in  1  downstream accept.
- `dst_data_o`  out  DATA_SIZE  registered output beat.
- `dst_last_o`  out  1  registered last flag.
- `dst_id_o`  out  ID_W  index of the master that sourced the current output beat.

## Operation
- State: round-robin pointer `rr_ptr` (ID_W), `locked` (1), `lock_id` (ID_W), plus output register (valid, data, last, id).
- `out_free = !dst_valid_o || dst_ready_i`. No source is granted unless `out_free` is 1.
- Candidate selection, unlocked: the first i with `src_valid_i[i]`, scanning `rr_ptr, rr_ptr+1, …` with explicit wrap at N_MASTER (no power-of-two modulo).
- Candidate selection, locked: only `lock_id`. If that master is not valid, no grant is made. Other masters wait even when valid.
- `src_ready_o[g] = out_free && src_valid_i[g]` for the selected g; all other bits are 0. Ready may depend on valid. Valid never depends on ready.
- Accept (`src_valid_i[g] && src_ready_o[g]`) loads the output register: data ← master g's slice, last ← `src_last_i[g]`, id ← g, valid ← 1.
- If `out_free` is 1 and nothing is accepted, valid ← 0. If `out_free` is 0, the output register holds every field unchanged.
- Lock update, LOCK_PKT=1: accept with last=0 sets locked=1, lock_id=g. Accept with last=1 clears locked.
- Pointer update: on accept with last=1 (or any accept when LOCK_PKT=0), `rr_ptr ← (g == N_MASTER-1) ? 0 : g+1`. Otherwise `rr_ptr` holds.
- LOCK_PKT=0: `locked` is held at 0 and `src_last_i` is passed through only.
- N_MASTER=1: degenerates to a one-stage pipeline register. `dst_id_o` is always 0.

## Timing
- Reset (rst=1 at a clock edge): `dst_valid_o`=0, `dst_data_o`=0, `dst_last_o`=0, `dst_id_o`=0, `rr_ptr`=0, `locked`=0.
  - `src_ready_o` is combinational and is 0 while `dst_valid_o`=0 and no source is valid.
  - Reset mid-packet drops the lock and any unaccepted output beat.
- Latency: beat accepted at edge k appears on `dst_*` after edge k.
- Throughput: one beat per cycle when `dst_ready_i` is held at 1.
- Backpressure: while `dst_valid_o`=1 and `dst_ready_i`=0, all `src_ready_o`=0 and the `dst_*` outputs are stable.
- Simultaneous pop and push: when `dst_ready_i`=1 with `dst_valid_o`=1, a new beat may be accepted in the same cycle, giving no bubble.
- Fairness: with all masters continuously valid and single-beat packets, grants rotate 0,1,…,N-1,0. Each master waits at most N_MASTER-1 packets.
- Wrap-around: if the pointer sits on N-1 and only master 0 is valid, master 0 is granted the same cycle.

## Test plan
- Reset/idle, N=3, DATA_SIZE=8: assert rst for 2 cycles with random inputs. Require all `dst_*`=0 after the edge. Release with no valids; require `src_ready_o`=0 and `dst_valid_o`=0.
- Round-robin, N=3: all valid, last=1, data 8'hA0+i, dst_ready=1. Require `dst_id_o` sequence 0,1,2,0,1,2 with data A0,A1,A2,… and one beat per cycle.
- Packet lock, LOCK_PKT=1: master 1 sends 3 beats (11,12,13; last on 13) while master 2 is valid throughout with 21. Require output 11,12,13,21, with `src_ready_o[2]`=0 until beat 13 is accepted.
- Lock with source gap: master 0 drops valid for 2 cycles mid-packet while master 1 is valid. Require no grant to master 1 and `dst_valid_o`=0 in the gap, then master 0's packet completes first.
- Backpressure: `dst_ready_i`=0 for 4 cycles with beat 8'h5A on the output. Require `dst_data_o`=5A, `dst_valid_o`=1 and `src_ready_o`=0 throughout. On release, require the next beat in the following cycle with no loss or duplication.
- LOCK_PKT=0, N=5 (non-power-of-two): pointer at 4, only master 0 valid. Require an immediate grant to 0, then pointer=1. Require beats from masters 0 and 3 with last=0 to interleave.

Source files
------------

// File: rtl/urp_pcie_rr_arbiter.sv
// -----------------------------------------------------------------------------
// urp_pcie_rr_arbiter
//
// N-way round-robin arbiter that merges N_MASTER valid/ready beat streams into
// one registered destination stream. With LOCK_PKT=1 a master that starts a
// packet keeps the grant until it delivers a beat flagged last; with
// LOCK_PKT=0 every beat is arbitrated on its own.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   src_valid_i  per-master beat valid               [N_MASTER]
//   src_ready_o  per-master accept, one-hot or zero   [N_MASTER]
//   src_data_i   packed per-master beats, master i at [i*DATA_SIZE +: DATA_SIZE]
//   src_last_i   per-master end-of-packet flag       [N_MASTER]
//   dst_valid_o  registered output valid
//   dst_ready_i  downstream accept
//   dst_data_o   registered output beat               [DATA_SIZE]
//   dst_last_o   registered output last flag
//   dst_id_o     index of the master that sourced the output beat [ID_W]
// -----------------------------------------------------------------------------
module urp_pcie_rr_arbiter #(
    parameter int N_MASTER  = 4,
    parameter int DATA_SIZE = 224,
    parameter int LOCK_PKT  = 1,
    localparam int ID_W     = (N_MASTER > 1) ? $clog2(N_MASTER) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTER-1:0]           src_valid_i,
    output logic [N_MASTER-1:0]           src_ready_o,
    input  logic [N_MASTER*DATA_SIZE-1:0] src_data_i,
    input  logic [N_MASTER-1:0]           src_last_i,
    output logic                          dst_valid_o,
    input  logic                          dst_ready_i,
    output logic [DATA_SIZE-1:0]          dst_data_o,
    output logic                          dst_last_o,
    output logic [ID_W-1:0]               dst_id_o
);

    localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_MASTER - 1);
    localparam logic [ID_W:0]   N_WIDE   = (ID_W + 1)'(N_MASTER);

    // Arbitration state
    logic [ID_W-1:0]      rr_ptr_reg;
    logic                 locked_reg;
    logic [ID_W-1:0]      lock_id_reg;

    // Output register
    logic                 dst_valid_reg;
    logic [DATA_SIZE-1:0] dst_data_reg;
    logic                 dst_last_reg;
    logic [ID_W-1:0]      dst_id_reg;

    // Combinational grant
    logic                 out_free;
    logic                 grant_found;
    logic [ID_W-1:0]      grant_id;
    logic                 accept;
    logic [ID_W:0]        scan_idx;
    logic [DATA_SIZE-1:0] src_data_arr [N_MASTER];

    // Unpack the flat data bus into an array so the grant can index it.
    generate
        for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_unpack
            assign src_data_arr[gi] = src_data_i[gi*DATA_SIZE +: DATA_SIZE];
        end
    endgenerate

    // The output slot can take a new beat if it is empty or draining this cycle.
    assign out_free = !dst_valid_reg || dst_ready_i;

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        if (LOCK_PKT != 0 && locked_reg) begin
            // Mid-packet: only the lock owner may proceed, even if it stalls.
            grant_found = src_valid_i[lock_id_reg];
            grant_id    = lock_id_reg;
        end else begin
            // Scan from the farthest offset back to rr_ptr so the nearest valid
            // master (in rotation order) is the last one written and wins.
            for (int k = N_MASTER - 1; k >= 0; k--) begin
                scan_idx = {1'b0, rr_ptr_reg} + (ID_W + 1)'(k);
                if (scan_idx >= N_WIDE) begin
                    scan_idx = scan_idx - N_WIDE;
                end
                if (src_valid_i[scan_idx[ID_W-1:0]]) begin
                    grant_found = 1'b1;
                    grant_id    = scan_idx[ID_W-1:0];
                end
            end
        end
    end

    assign accept = out_free && grant_found;

    always_comb begin
        src_ready_o = '0;
        if (accept) begin
            src_ready_o[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg    <= '0;
            locked_reg    <= 1'b0;
            lock_id_reg   <= '0;
            dst_valid_reg <= 1'b0;
            dst_data_reg  <= '0;
            dst_last_reg  <= 1'b0;
            dst_id_reg    <= '0;
        end else begin
            // When the slot is busy and stalled, every output field holds.
            if (out_free) begin
                dst_valid_reg <= accept;
                if (accept) begin
                    dst_data_reg <= src_data_arr[grant_id];
                    dst_last_reg <= src_last_i[grant_id];
                    dst_id_reg   <= grant_id;
                end
            end

            if (accept) begin
                if (LOCK_PKT != 0) begin
                    locked_reg <= !src_last_i[grant_id];
                    if (!src_last_i[grant_id]) begin
                        lock_id_reg <= grant_id;
                    end
                end
                // Advance past the winner only when its packet is finished,
                // so the rotation is per packet rather than per beat.
                if (LOCK_PKT == 0 || src_last_i[grant_id]) begin
                    rr_ptr_reg <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                end
            end
        end
    end

    assign dst_valid_o = dst_valid_reg;
    assign dst_data_o  = dst_data_reg;
    assign dst_last_o  = dst_last_reg;
    assign dst_id_o    = dst_id_reg;

endmodule

// File: tb/tb_urp_pcie_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_urp_pcie_rr_arbiter
//
// Two arbiter instances: a 3-master packet-locking one and a 5-master per-beat
// one, both with 8-bit beats. Table rows give per-cycle inputs plus the
// expected src_ready_o and dst_valid_o; every accepted beat is pushed to a
// scoreboard queue and compared when it leaves the output register.
// -----------------------------------------------------------------------------
module tb_urp_pcie_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic [2:0]  valid3, ready3, last3;
    logic [23:0] data3;
    logic        dvalid3, dready3, dlast3;
    logic [7:0]  ddata3;
    logic [1:0]  did3;

    logic [4:0]  valid5, ready5, last5;
    logic [39:0] data5;
    logic        dvalid5, dready5, dlast5;
    logic [7:0]  ddata5;
    logic [2:0]  did5;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string           tag;
        logic [4:0]      valid;
        logic [4:0]      last;
        logic [4:0][7:0] data;
        logic            dready;
        logic [4:0]      exp_ready;
        logic            exp_dv;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         id;
    } beat_t;

    beat_t sb3[$];
    beat_t sb5[$];
    vec_t  tbl3[$];
    vec_t  tbl5[$];

    always #5 clk = ~clk;

    urp_pcie_rr_arbiter #(.N_MASTER(3), .DATA_SIZE(8), .LOCK_PKT(1)) u_dut3 (
        .clk(clk), .rst(rst),
        .src_valid_i(valid3), .src_ready_o(ready3), .src_data_i(data3), .src_last_i(last3),
        .dst_valid_o(dvalid3), .dst_ready_i(dready3), .dst_data_o(ddata3),
        .dst_last_o(dlast3), .dst_id_o(did3)
    );

    urp_pcie_rr_arbiter #(.N_MASTER(5), .DATA_SIZE(8), .LOCK_PKT(0)) u_dut5 (
        .clk(clk), .rst(rst),
        .src_valid_i(valid5), .src_ready_o(ready5), .src_data_i(data5), .src_last_i(last5),
        .dst_valid_o(dvalid5), .dst_ready_i(dready5), .dst_data_o(ddata5),
        .dst_last_o(dlast5), .dst_id_o(did5)
    );

    function automatic vec_t mk(input string tag, input logic [4:0] valid, input logic [4:0] last,
                                input logic [4:0][7:0] data, input logic dready,
                                input logic [4:0] exp_ready, input logic exp_dv);
        vec_t v;
        v.tag = tag; v.valid = valid; v.last = last; v.data = data;
        v.dready = dready; v.exp_ready = exp_ready; v.exp_dv = exp_dv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Apply one row at posedge+1, check at the following negedge, return at
    // the next posedge+1.
    task automatic step(input int which, input vec_t v);
        logic [4:0] rdy;
        logic       dv, dl;
        logic [7:0] dd;
        int         did;
        beat_t      b;
        if (which == 0) begin
            valid3 = v.valid[2:0]; last3 = v.last[2:0]; dready3 = v.dready;
            for (int i = 0; i < 3; i++) data3[i*8 +: 8] = v.data[i];
        end else begin
            valid5 = v.valid; last5 = v.last; dready5 = v.dready;
            for (int i = 0; i < 5; i++) data5[i*8 +: 8] = v.data[i];
        end
        @(negedge clk);
        if (which == 0) begin
            rdy = {2'b00, ready3}; dv = dvalid3; dd = ddata3; dl = dlast3; did = int'(did3);
        end else begin
            rdy = ready5; dv = dvalid5; dd = ddata5; dl = dlast5; did = int'(did5);
        end
        chk({v.tag, ".ready"}, 32'(rdy), 32'(v.exp_ready));
        chk({v.tag, ".dvalid"}, 32'(dv), 32'(v.exp_dv));
        if (dv && v.dready) begin
            if ((which == 0 && sb3.size() == 0) || (which != 0 && sb5.size() == 0)) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s.beat: got id=%0d data=%0h with empty scoreboard", v.tag, did, dd);
            end else begin
                b = (which == 0) ? sb3.pop_front() : sb5.pop_front();
                chk({v.tag, ".beat(id,last,data)"},
                    {16'h0, dd, 3'b000, dl, 4'(did)},
                    {16'h0, b.data, 3'b000, b.last, 4'(b.id)});
            end
        end
        if (v.exp_ready != 5'b0) begin
            for (int i = 0; i < 5; i++) begin
                if (v.exp_ready[i]) begin
                    b.data = v.data[i]; b.last = v.last[i]; b.id = i;
                    if (which == 0) sb3.push_back(b); else sb5.push_back(b);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- stimulus tables ----------------
        // Round robin: all valid, single-beat packets.
        tbl3.push_back(mk("rr0", 5'b00111, 5'b00111, {8'h0, 8'h0, 8'hA2, 8'hA1, 8'hA0}, 1, 5'b00001, 0));
        tbl3.push_back(mk("rr1", 5'b00111, 5'b00111, {8'h0, 8'h0, 8'hA2, 8'hA1, 8'hA0}, 1, 5'b00010, 1));
        tbl3.push_back(mk("rr2", 5'b00111, 5'b00111, {8'h0, 8'h0, 8'hA2, 8'hA1, 8'hA0}, 1, 5'b00100, 1));
        tbl3.push_back(mk("rr3", 5'b00111, 5'b00111, {8'h0, 8'h0, 8'hA2, 8'hA1, 8'hA0}, 1, 5'b00001, 1));
        tbl3.push_back(mk("rr4", 5'b00111, 5'b00111, {8'h0, 8'h0, 8'hA2, 8'hA1, 8'hA0}, 1, 5'b00010, 1));
        tbl3.push_back(mk("rr5", 5'b00111, 5'b00111, {8'h0, 8'h0, 8'hA2, 8'hA1, 8'hA0}, 1, 5'b00100, 1));
        tbl3.push_back(mk("rr6", 5'b00000, 5'b00000, {8'h0, 8'h0, 8'h00, 8'h00, 8'h00}, 1, 5'b00000, 1));
        // Packet lock: master 1 sends 11,12,13 while master 2 waits with 21.
        tbl3.push_back(mk("lk0", 5'b00110, 5'b00100, {8'h0, 8'h0, 8'h21, 8'h11, 8'h00}, 1, 5'b00010, 0));
        tbl3.push_back(mk("lk1", 5'b00110, 5'b00100, {8'h0, 8'h0, 8'h21, 8'h12, 8'h00}, 1, 5'b00010, 1));
        tbl3.push_back(mk("lk2", 5'b00110, 5'b00110, {8'h0, 8'h0, 8'h21, 8'h13, 8'h00}, 1, 5'b00010, 1));
        tbl3.push_back(mk("lk3", 5'b00100, 5'b00100, {8'h0, 8'h0, 8'h21, 8'h13, 8'h00}, 1, 5'b00100, 1));
        tbl3.push_back(mk("lk4", 5'b00000, 5'b00000, {8'h0, 8'h0, 8'h00, 8'h00, 8'h00}, 1, 5'b00000, 1));
        // Lock owner (master 0) gaps for two cycles; master 1 must wait.
        tbl3.push_back(mk("gp0", 5'b00011, 5'b00010, {8'h0, 8'h0, 8'h00, 8'h31, 8'h01}, 1, 5'b00001, 0));
        tbl3.push_back(mk("gp1", 5'b00010, 5'b00010, {8'h0, 8'h0, 8'h00, 8'h31, 8'h01}, 1, 5'b00000, 1));
        tbl3.push_back(mk("gp2", 5'b00010, 5'b00010, {8'h0, 8'h0, 8'h00, 8'h31, 8'h01}, 1, 5'b00000, 0));
        tbl3.push_back(mk("gp3", 5'b00011, 5'b00010, {8'h0, 8'h0, 8'h00, 8'h31, 8'h02}, 1, 5'b00001, 0));
        tbl3.push_back(mk("gp4", 5'b00011, 5'b00011, {8'h0, 8'h0, 8'h00, 8'h31, 8'h03}, 1, 5'b00001, 1));
        tbl3.push_back(mk("gp5", 5'b00010, 5'b00010, {8'h0, 8'h0, 8'h00, 8'h31, 8'h03}, 1, 5'b00010, 1));
        tbl3.push_back(mk("gp6", 5'b00000, 5'b00000, {8'h0, 8'h0, 8'h00, 8'h00, 8'h00}, 1, 5'b00000, 1));

        // Five masters, per-beat arbitration.
        tbl5.push_back(mk("n5_0", 5'b01000, 5'b00000, {8'h0, 8'h33, 8'h0, 8'h00, 8'h00}, 1, 5'b01000, 0));
        tbl5.push_back(mk("n5_1", 5'b00001, 5'b00000, {8'h0, 8'h00, 8'h0, 8'h00, 8'h0A}, 1, 5'b00001, 1));
        tbl5.push_back(mk("n5_2", 5'b00011, 5'b00010, {8'h0, 8'h00, 8'h0, 8'h1B, 8'h0B}, 1, 5'b00010, 1));
        tbl5.push_back(mk("n5_3", 5'b01001, 5'b00000, {8'h0, 8'h3C, 8'h0, 8'h00, 8'h0C}, 1, 5'b01000, 1));
        tbl5.push_back(mk("n5_4", 5'b01001, 5'b00000, {8'h0, 8'h3D, 8'h0, 8'h00, 8'h0D}, 1, 5'b00001, 1));
        tbl5.push_back(mk("n5_5", 5'b01001, 5'b00000, {8'h0, 8'h3E, 8'h0, 8'h00, 8'h0E}, 1, 5'b01000, 1));
        tbl5.push_back(mk("n5_6", 5'b00000, 5'b00000, {8'h0, 8'h00, 8'h0, 8'h00, 8'h00}, 1, 5'b00000, 1));
        tbl5.push_back(mk("n5_7", 5'b00000, 5'b00000, {8'h0, 8'h00, 8'h0, 8'h00, 8'h00}, 1, 5'b00000, 0));

        // ---------------- reset with random inputs ----------------
        rst = 1'b1;
        valid5 = '0; last5 = '0; data5 = '0; dready5 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            valid3 = 3'($urandom); last3 = 3'($urandom); data3 = 24'($urandom); dready3 = 1'($urandom);
            @(posedge clk);
            #1;
        end
        chk("reset.dst3", {22'h0, dvalid3, dlast3, ddata3}, 32'h0);
        chk("reset.id3", 32'(did3), 32'h0);
        chk("reset.dst5", {22'h0, dvalid5, dlast5, ddata5}, 32'h0);
        rst = 1'b0;
        valid3 = '0; last3 = '0; data3 = '0; dready3 = 1'b1;
        @(negedge clk);
        chk("idle.ready3", 32'(ready3), 32'h0);
        chk("idle.dvalid3", 32'(dvalid3), 32'h0);
        @(posedge clk);
        #1;

        // ---------------- table: round robin, lock, gap ----------------
        for (int i = 0; i < tbl3.size(); i++) step(0, tbl3[i]);

        // ---------------- backpressure on beat 5A ----------------
        step(0, mk("bp0", 5'b00001, 5'b00001, {8'h0, 8'h0, 8'h00, 8'h00, 8'h5A}, 1, 5'b00001, 0));
        chk("bp0.hold", {23'h0, dvalid3, ddata3}, {23'h0, 1'b1, 8'h5A});
        for (int c = 1; c <= 4; c++) begin
            step(0, mk($sformatf("bp%0d", c), 5'b00011, 5'b00011,
                       {8'h0, 8'h0, 8'h00, 8'h6A, 8'h5B}, 0, 5'b00000, 1));
            chk($sformatf("bp%0d.hold", c), {23'h0, dvalid3, ddata3}, {23'h0, 1'b1, 8'h5A});
        end
        step(0, mk("bp5", 5'b00011, 5'b00011, {8'h0, 8'h0, 8'h00, 8'h6A, 8'h5B}, 1, 5'b00010, 1));
        step(0, mk("bp6", 5'b00001, 5'b00001, {8'h0, 8'h0, 8'h00, 8'h00, 8'h5B}, 1, 5'b00001, 1));
        step(0, mk("bp7", 5'b00000, 5'b00000, {8'h0, 8'h0, 8'h00, 8'h00, 8'h00}, 1, 5'b00000, 1));

        // ---------------- reset mid-packet drops the lock ----------------
        step(0, mk("mr0", 5'b00010, 5'b00000, {8'h0, 8'h0, 8'h00, 8'h41, 8'h00}, 1, 5'b00010, 0));
        rst = 1'b1;
        valid3 = '0;
        @(posedge clk);
        #1;
        chk("mr.reset_dst3", {22'h0, dvalid3, dlast3, ddata3}, 32'h0);
        rst = 1'b0;
        sb3.delete();
        step(0, mk("mr1", 5'b00011, 5'b00011, {8'h0, 8'h0, 8'h00, 8'h43, 8'h42}, 1, 5'b00001, 0));
        step(0, mk("mr2", 5'b00000, 5'b00000, {8'h0, 8'h0, 8'h00, 8'h00, 8'h00}, 1, 5'b00000, 1));

        // ---------------- N=5, LOCK_PKT=0 ----------------
        for (int i = 0; i < tbl5.size(); i++) step(1, tbl5[i]);

        chk("sb3.leftover", 32'(sb3.size()), 32'h0);
        chk("sb5.leftover", 32'(sb5.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
